ch_readout_serializer: RTL
==========================

Name: ch_readout_serializer

Overview:
- Transmit end of the channel readout path.
- On entry to STATE_READOUT, snapshots the per-buffer sample counters and the trigger count into a frame register, then shifts the frame out MSB-first, one bit per shift-enable, on a single serial data line toward the chip-level readout chain.
- Sits beside the channel control FSM and consumes its state_t encoding directly.

Parameters:
- CNT_WIDTH, 12, width of each sample counter.
- N_COUNTERS, 5, number of counters: buffers A, B, C, D, E, in index order 0..4.
- TRIG_WIDTH, 8, width of the trigger count.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- state  in  4  current channel FSM state (state_t encoding: INIT=0, STOPPED=1, ... SAMPLING_ALL=9, READOUT=10).
- counters  in  N_COUNTERS*CNT_WIDTH  flat counter bus; counter i occupies bits [i*CNT_WIDTH +: CNT_WIDTH].
- trig_count  in  TRIG_WIDTH  trigger count.
- shift_en  in  1  single-cycle shift request, already synchronized to clk.
- sdo  out  1  serial data out; the current frame bit.
- busy  out  1  high while a frame is loaded and not fully shifted.
- frame_done  out  1  one-cycle pulse after the last bit is consumed.

Behaviour:
- Reset: sdo=0, busy=0, frame_done=0, bit counter=0, prev_state=INIT, FSM=IDLE.
- FSM states: IDLE, SHIFT, HOLD.
- Frame layout, FRAME_LEN = 4 + TRIG_WIDTH + N_COUNTERS*CNT_WIDTH + 1 (73 at defaults), sent in this order:
  - header 4'b1010;
  - trig_count, MSB first;
  - counter 0 through counter N_COUNTERS-1, each MSB first;
  - 1 even-parity bit over trig_count and all counters (XOR reduction).
- Load:
  - Triggered when state==READOUT and prev_state!=READOUT.
  - Frame register is captured from inputs in that cycle; FSM goes to SHIFT.
  - From the next cycle: busy=1, sdo=header MSB (1).
  - A shift_en asserted in the load cycle is ignored.
- SHIFT:
  - Each cycle with shift_en=1 advances one bit; sdo shows the new bit the next cycle.
  - The bit counter counts bits consumed.
  - shift_en=1 while the parity bit is presented (bit FRAME_LEN-1) completes the frame: next cycle busy=0, sdo=0, frame_done=1 for exactly one cycle, FSM goes to HOLD.
- HOLD:
  - Frame complete, still in READOUT; further shift_en ignored and sdo stays 0.
  - state!=READOUT returns FSM to IDLE.
  - No reload until READOUT is exited and re-entered.
- Abort: state leaves READOUT while in SHIFT → next cycle busy=0, sdo=0, no frame_done, FSM goes to IDLE, bit counter cleared.
- state==INIT at any time: same as abort.
- Re-entry into READOUT always reloads from the current inputs; old frame contents are never re-sent.
- Counters and trig_count changing after the load cycle do not affect the frame in flight.
- rst asserted mid-frame → all outputs return to reset values next cycle.
- Bit counter width is $clog2(FRAME_LEN+1); no wrap-around inside a frame.
- Out-of-range state values (11–15) are treated as non-READOUT.

Test Plan:
1. Defaults: trig_count=8'hA5, counters={12'h001,12'h800,12'hFFF,12'h000,12'h123}; enter READOUT; pulse shift_en 73 times → sdo sequence 1010, 10100101, then counters 0..4 MSB-first, parity = XOR of payload; frame_done one cycle after the 73rd shift; busy high for exactly that window.
2. Load-cycle shift: shift_en held high from the READOUT entry cycle → first captured bit is 1 (header MSB, not skipped); frame_done asserts after 73 consumed shifts (74 cycles including the load cycle).
3. Abort: after 20 shifts, state→STOPPED → next cycle busy=0, sdo=0, frame_done never asserts; re-enter READOUT with trig_count=8'h3C → new frame starts with header 1010 then 00111100.
4. Post-load input change: load with trig_count=8'hFF, change it to 8'h00 the next cycle → shifted trig field is 11111111.
5. Completion hold: after frame_done, 10 more shift_en pulses while still in READOUT → sdo stays 0, busy=0, no second frame_done.
6. Reset mid-frame: assert rst at shift 40 → next cycle sdo=0, busy=0, frame_done=0; a later READOUT entry produces a full fresh 73-bit frame.

Source files
------------

// File: rtl/ch_readout_serializer.sv
// Channel readout serializer: snapshots trigger count and sample counters on
// READOUT entry, then shifts a parity-protected frame out MSB-first on sdo.
module ch_readout_serializer #(
   parameter int CNT_WIDTH  = 12,
   parameter int N_COUNTERS = 5,
   parameter int TRIG_WIDTH = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [3:0]                      state,
   input  logic [N_COUNTERS*CNT_WIDTH-1:0] counters,
   input  logic [TRIG_WIDTH-1:0]           trig_count,
   input  logic                            shift_en,
   output logic                            sdo,
   output logic                            busy,
   output logic                            frame_done
);

   localparam int PAYLOAD_LEN = TRIG_WIDTH + N_COUNTERS*CNT_WIDTH;
   localparam int FRAME_LEN   = 4 + PAYLOAD_LEN + 1;
   localparam int BIT_CNT_W   = $clog2(FRAME_LEN + 1);

   localparam logic [3:0]           ST_INIT    = 4'd0;
   localparam logic [3:0]           ST_READOUT = 4'd10;
   localparam logic [3:0]           HEADER     = 4'b1010;
   localparam logic [BIT_CNT_W-1:0] LAST_BIT   = BIT_CNT_W'(FRAME_LEN - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } ser_state_t;

   ser_state_t             r_state;
   ser_state_t             w_next_state;
   logic [3:0]             r_prev_state;
   logic [FRAME_LEN-1:0]   r_frame;
   logic [BIT_CNT_W-1:0]   r_bit_cnt;
   logic                   r_frame_done;

   logic                   w_in_readout;
   logic                   w_load;
   logic                   w_shift;
   logic                   w_last_shift;
   logic [PAYLOAD_LEN-1:0] w_payload;
   logic [FRAME_LEN-1:0]   w_frame;

   // Codes 11..15 and INIT all fall out as "not READOUT", which aborts a frame.
   assign w_in_readout = (state == ST_READOUT);
   assign w_load       = w_in_readout && (r_prev_state != ST_READOUT);
   assign w_shift      = (r_state == SHIFT) && w_in_readout && shift_en;
   assign w_last_shift = w_shift && (r_bit_cnt == LAST_BIT);

   // Trigger count first, then counter 0 .. N-1, each MSB-first.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      w_payload = '0;
      w_payload[PAYLOAD_LEN-1 -: TRIG_WIDTH] = trig_count;
      for (int i = 0; i < N_COUNTERS; i++) begin
         w_payload[PAYLOAD_LEN-TRIG_WIDTH-1-i*CNT_WIDTH -: CNT_WIDTH] =
            counters[i*CNT_WIDTH +: CNT_WIDTH];
      end
   end

   assign w_frame = {HEADER, w_payload, ^w_payload};

   // State register
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_load) w_next_state = SHIFT;
         end
         SHIFT: begin
            if (!w_in_readout)     w_next_state = IDLE;
            else if (w_last_shift) w_next_state = HOLD;
         end
         HOLD: begin
            if (!w_in_readout) w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy       = (r_state == SHIFT);
      sdo        = (r_state == SHIFT) ? r_frame[FRAME_LEN-1] : 1'b0;
      frame_done = r_frame_done;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev_state <= ST_INIT;
         r_bit_cnt    <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_prev_state <= state;
         r_frame_done <= w_last_shift;
         if (w_load || (w_next_state == IDLE)) begin
            r_bit_cnt <= '0;
         end else if (w_shift) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
         end
      end
   end

   // NOTE: the frame shift register is data-only and left unreset; sdo is gated by the FSM.
   always_ff @(posedge clk) begin
      if (w_load) begin
         r_frame <= w_frame;
      end else if (w_shift) begin
         r_frame <= {r_frame[FRAME_LEN-2:0], 1'b0};
      end
   end

endmodule
